// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-3 target exposing an accelerometer-style register map.
// Define SPI_RESP_DRDY_INT_EN to add INT_ENABLE (0x2E) and the data-ready interrupt on int1.
module spi_accel_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic [7:0]  bw_rate,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        reg_wr,
  output logic [5:0]  reg_wr_addr,
  output logic        int1
);
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, WAIT_CS} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q, sclk_d, cs_q, cs_d, cnt_q, cnt_d;
  logic [1:0] sdi_q, sdi_d;
  logic [7:0] sh_q, sh_d, bw_q, bw_d, pc_q, pc_d, df_q, df_d, rd_data, byte_in;
  logic [5:0] addr_q, addr_d, wr_addr_q, wr_addr_d, addr_inc, ld_addr;
  logic       mb_q, mb_d, sdo_q, sdo_d, oe_q, oe_d, wr_q, wr_d, pend_vld_q, pend_vld_d;
  logic [47:0] snap_q, snap_d, pend_q, pend_d;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n_s, byte_done, wr_ok, wr_commit;
  logic       snap_load, pend_commit;
`ifdef SPI_RESP_DRDY_INT_EN
  logic [7:0] ien_q, ien_d;
  logic       drdy_q, drdy_d;
  assign int1 = drdy_q & ien_q[7];
`else
  assign int1 = 1'b0;
`endif
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_n_s    = cs_q[1];
  assign byte_in   = {sh_q[6:0], sdi_q[1]};
  assign addr_inc  = addr_q + {5'd0, mb_q};
  // Address of the byte about to be loaded for shifting out: command target or next data address
  assign ld_addr   = (state_q == CMD) ? byte_in[5:0] : addr_inc;
  assign spi_sdo     = sdo_q;
  assign spi_sdo_oe  = oe_q;
  assign bw_rate     = bw_q;
  assign power_ctl   = pc_q;
  assign data_format = df_q;
  assign reg_wr      = wr_q;
  assign reg_wr_addr = wr_addr_q;
  always_comb begin
    case (ld_addr)
      6'h00:   rd_data = 8'hE5;
      6'h2C:   rd_data = bw_q;
      6'h2D:   rd_data = pc_q;
`ifdef SPI_RESP_DRDY_INT_EN
      6'h2E:   rd_data = ien_q;
`endif
      6'h31:   rd_data = df_q;
      6'h32:   rd_data = snap_q[7:0];
      6'h33:   rd_data = snap_q[15:8];
      6'h34:   rd_data = snap_q[23:16];
      6'h35:   rd_data = snap_q[31:24];
      6'h36:   rd_data = snap_q[39:32];
      6'h37:   rd_data = snap_q[47:40];
      default: rd_data = 8'h00;
    endcase
  end
  always_comb begin
    sclk_d = {sclk_q[1:0], spi_sclk};
    cs_d = {cs_q[1:0], spi_cs_n};
    sdi_d = {sdi_q[0], spi_sdi};
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    addr_d = addr_q;
    mb_d = mb_q;
    byte_done = 1'b0;
    if (cs_rise) state_d = IDLE;
    else case (state_q)
      IDLE: if (cs_fall) begin
        state_d = CMD;
        cnt_d = 3'd0;
      end
      CMD, WDATA, RDATA: begin
        if (sclk_fall && state_q == RDATA) sh_d = {sh_q[6:0], 1'b0};
        if (sclk_rise) begin
          cnt_d = cnt_q + 3'd1;
          sh_d = (state_q == RDATA) ? sh_q : byte_in;
          if (cnt_q == 3'd7) begin
            byte_done = 1'b1;
            addr_d = ld_addr;
            mb_d = (state_q == CMD) ? byte_in[6] : mb_q;
            if (state_q == CMD) state_d = byte_in[7] ? RDATA : WDATA;
            if (state_d == RDATA) sh_d = rd_data;
          end
        end
      end
      default: ;
    endcase
`ifdef SPI_RESP_DRDY_INT_EN
    wr_ok = addr_q == 6'h2C || addr_q == 6'h2D || addr_q == 6'h2E || addr_q == 6'h31;
`else
    wr_ok = addr_q == 6'h2C || addr_q == 6'h2D || addr_q == 6'h31;
`endif
    wr_commit = byte_done && state_q == WDATA && wr_ok;
    wr_d = wr_commit;
    wr_addr_d = wr_commit ? addr_q : wr_addr_q;
    bw_d = (wr_commit && addr_q == 6'h2C) ? byte_in : bw_q;
    pc_d = (wr_commit && addr_q == 6'h2D) ? byte_in : pc_q;
    df_d = (wr_commit && addr_q == 6'h31) ? byte_in : df_q;
    oe_d = state_d == RDATA;
    sdo_d = oe_d & ((state_q == RDATA && sclk_fall) ? sh_q[7] : sdo_q);
    // Samples arriving mid-transaction wait in pend until cs_n rises
    pend_commit = cs_rise & pend_vld_q;
    pend_d = (sample_valid & ~cs_n_s) ? {sample_z, sample_y, sample_x} : pend_q;
    pend_vld_d = (sample_valid & ~cs_n_s) | (pend_vld_q & ~cs_rise);
    snap_load = pend_commit | (sample_valid & cs_n_s);
    snap_d = (sample_valid & cs_n_s) ? {sample_z, sample_y, sample_x} : pend_commit ? pend_q : snap_q;
`ifdef SPI_RESP_DRDY_INT_EN
    ien_d = (wr_commit && addr_q == 6'h2E) ? byte_in : ien_q;
    drdy_d = snap_load | (drdy_q & ~(byte_done && state_q == RDATA && addr_q == 6'h37));
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= spi_cs_n ? IDLE : WAIT_CS;
      sclk_q <= 3'b111;
      cs_q <= 3'b111;
      sdi_q <= 2'b00;
      cnt_q <= 3'd0;
      sh_q <= 8'h00;
      addr_q <= 6'd0;
      mb_q <= 1'b0;
      bw_q <= 8'h0A;
      pc_q <= 8'h00;
      df_q <= 8'h00;
      sdo_q <= 1'b0;
      oe_q <= 1'b0;
      wr_q <= 1'b0;
      wr_addr_q <= 6'd0;
      snap_q <= 48'd0;
      pend_q <= 48'd0;
      pend_vld_q <= 1'b0;
`ifdef SPI_RESP_DRDY_INT_EN
      ien_q <= 8'h00;
      drdy_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      sdi_q <= sdi_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      addr_q <= addr_d;
      mb_q <= mb_d;
      bw_q <= bw_d;
      pc_q <= pc_d;
      df_q <= df_d;
      sdo_q <= sdo_d;
      oe_q <= oe_d;
      wr_q <= wr_d;
      wr_addr_q <= wr_addr_d;
      snap_q <= snap_d;
      pend_q <= pend_d;
      pend_vld_q <= pend_vld_d;
`ifdef SPI_RESP_DRDY_INT_EN
      ien_q <= ien_d;
      drdy_q <= drdy_d;
`endif
    end
  end
endmodule

// File: tb/tb_spi_accel_responder.sv
// tb_spi_accel_responder: directed table-driven bench for spi_accel_responder.
// Build with SPI_RESP_DRDY_INT_EN defined to exercise the data-ready interrupt.
module tb_spi_accel_responder;
  logic clk = 1'b0, reset = 1'b1;
  logic spi_sclk = 1'b1, spi_cs_n = 1'b1, spi_sdi = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic spi_sdo, spi_sdo_oe, reg_wr, int1;
  logic [7:0] bw_rate, power_ctl, data_format;
  logic [5:0] reg_wr_addr;
`ifdef SPI_RESP_DRDY_INT_EN
  localparam bit DRDY = 1'b1;
`else
  localparam bit DRDY = 1'b0;
`endif
  spi_accel_responder dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .sample_valid(sample_valid),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .bw_rate(bw_rate), .power_ctl(power_ctl), .data_format(data_format),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .int1(int1)
  );
  always #10 clk = ~clk;
  int n_asrt = 0, n_fail = 0, wr_total = 0;
  logic [5:0] wr_last = '0;
  always @(negedge clk) if (reg_wr) begin
    wr_total++;
    wr_last = reg_wr_addr;
  end
  typedef struct {
    logic [7:0] cmd, dat, rd;
    int         wr;
    logic [7:0] pc, bw, df;
  } vec_t;
  vec_t vt [14];
  logic [7:0] e1 [6] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F};
  logic [7:0] e2 [6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
  logic [7:0] e3 [6] = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05};
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx,
                      output logic oe_any, output logic oe_all);
    rx = '0;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      spi_sclk = 1'b0;
      spi_sdi = tx[i];
      repeat (5) @(negedge clk);
      rx[i] = spi_sdo;
      oe_any |= spi_sdo_oe;
      oe_all &= spi_sdo_oe;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic cs_lo();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic cs_hi();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask
  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_x = x;
    sample_y = y;
    sample_z = z;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask
  task automatic multi_read(input logic [7:0] cmd, input string nm, input logic [7:0] ex [6]);
    logic [7:0] rx;
    logic a, b;
    cs_lo();
    xfer(cmd, 8, rx, a, b);
    for (int k = 0; k < 6; k++) begin
      xfer(8'h00, 8, rx, a, b);
      chk($sformatf("%s_b%0d", nm, k), rx, ex[k]);
    end
    cs_hi();
  endtask
  initial begin
    logic [7:0] rx;
    logic oa, ob, oc, od;
    int w0;
    vt[0]  = '{8'h80, 8'h00, 8'hE5, 0, 8'h00, 8'h0A, 8'h00};
    vt[1]  = '{8'hAC, 8'h00, 8'h0A, 0, 8'h00, 8'h0A, 8'h00};
    vt[2]  = '{8'hAD, 8'h00, 8'h00, 0, 8'h00, 8'h0A, 8'h00};
    vt[3]  = '{8'h2D, 8'h08, 8'h00, 1, 8'h08, 8'h0A, 8'h00};
    vt[4]  = '{8'hAD, 8'h00, 8'h08, 0, 8'h08, 8'h0A, 8'h00};
    vt[5]  = '{8'h90, 8'h00, 8'h00, 0, 8'h08, 8'h0A, 8'h00};
    vt[6]  = '{8'h10, 8'h55, 8'h00, 0, 8'h08, 8'h0A, 8'h00};
    vt[7]  = '{8'h00, 8'h12, 8'h00, 0, 8'h08, 8'h0A, 8'h00};
    vt[8]  = '{8'h80, 8'h00, 8'hE5, 0, 8'h08, 8'h0A, 8'h00};
    vt[9]  = '{8'h2C, 8'h0F, 8'h00, 1, 8'h08, 8'h0F, 8'h00};
    vt[10] = '{8'hAC, 8'h00, 8'h0F, 0, 8'h08, 8'h0F, 8'h00};
    vt[11] = '{8'h31, 8'h0B, 8'h00, 1, 8'h08, 8'h0F, 8'h0B};
    vt[12] = '{8'hB1, 8'h00, 8'h0B, 0, 8'h08, 8'h0F, 8'h0B};
    vt[13] = '{8'h3F, 8'h77, 8'h00, 0, 8'h08, 8'h0F, 8'h0B};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sdo", spi_sdo, 1'b0);
    chk("rst_oe", spi_sdo_oe, 1'b0);
    chk("rst_wr", reg_wr, 1'b0);
    chk("rst_wr_addr", reg_wr_addr, 6'd0);
    chk("rst_int1", int1, 1'b0);
    chk("rst_bw", bw_rate, 8'h0A);
    chk("rst_pc", power_ctl, 8'h00);
    chk("rst_df", data_format, 8'h00);
    // Write to DATA_FORMAT aborted after 5 data bits
    w0 = wr_total;
    cs_lo();
    xfer(8'h31, 8, rx, oa, ob);
    xfer(8'hFF, 5, rx, oa, ob);
    cs_hi();
    chk("abort_df", data_format, 8'h00);
    chk("abort_wr", wr_total - w0, 0);
    for (int k = 0; k < 14; k++) begin
      w0 = wr_total;
      cs_lo();
      xfer(vt[k].cmd, 8, rx, oa, ob);
      chk($sformatf("v%0d_oe_cmd", k), oa, 1'b0);
      xfer(vt[k].dat, 8, rx, oc, od);
      cs_hi();
      if (vt[k].cmd[7]) begin
        chk($sformatf("v%0d_rd", k), rx, vt[k].rd);
        chk($sformatf("v%0d_oe_dat", k), od, 1'b1);
      end else chk($sformatf("v%0d_oe_wdat", k), oc, 1'b0);
      chk($sformatf("v%0d_oe_after", k), spi_sdo_oe, 1'b0);
      chk($sformatf("v%0d_wr_cnt", k), wr_total - w0, vt[k].wr);
      if (vt[k].wr != 0) chk($sformatf("v%0d_wr_addr", k), wr_last, vt[k].cmd[5:0]);
      chk($sformatf("v%0d_pc", k), power_ctl, vt[k].pc);
      chk($sformatf("v%0d_bw", k), bw_rate, vt[k].bw);
      chk($sformatf("v%0d_df", k), data_format, vt[k].df);
    end
    // Snapshot stays frozen for the whole transaction
    pulse_sample(16'h1234, 16'hABCD, 16'h0F0F);
    repeat (2) @(negedge clk);
    cs_lo();
    xfer(8'hF2, 8, rx, oa, ob);
    for (int k = 0; k < 6; k++) begin
      xfer(8'h00, 8, rx, oa, ob);
      chk($sformatf("snap1_b%0d", k), rx, e1[k]);
      if (k == 1) pulse_sample(16'h1111, 16'h2222, 16'h3333);
    end
    cs_hi();
    multi_read(8'hF2, "snap2", e2);
    // Address wrap 0x3F -> 0x00
    cs_lo();
    xfer(8'hFF, 8, rx, oa, ob);
    xfer(8'h00, 8, rx, oa, ob);
    chk("wrap_3f", rx, 8'h00);
    xfer(8'h00, 8, rx, oa, ob);
    chk("wrap_00", rx, 8'hE5);
    cs_hi();
    // Reset mid-read while cs_n is low
    cs_lo();
    xfer(8'h80, 8, rx, oa, ob);
    xfer(8'h00, 3, rx, oa, ob);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    xfer(8'h00, 5, rx, oa, ob);
    chk("rstmid_oe_a", oa, 1'b0);
    xfer(8'h00, 8, rx, oa, ob);
    chk("rstmid_oe_b", oa, 1'b0);
    chk("rstmid_sdo", rx, 8'h00);
    cs_hi();
    chk("rstmid_pc", power_ctl, 8'h00);
    chk("rstmid_bw", bw_rate, 8'h0A);
    cs_lo();
    xfer(8'h80, 8, rx, oa, ob);
    xfer(8'h00, 8, rx, oa, ob);
    cs_hi();
    chk("rstmid_rd", rx, 8'hE5);
    chk("rstmid_oe_rd", ob, 1'b1);
    // Data-ready interrupt
    w0 = wr_total;
    cs_lo();
    xfer(8'h2E, 8, rx, oa, ob);
    xfer(8'h80, 8, rx, oa, ob);
    cs_hi();
    chk("ien_wr", wr_total - w0, DRDY ? 1 : 0);
    chk("int_pre", int1, 1'b0);
    cs_lo();
    xfer(8'hAE, 8, rx, oa, ob);
    xfer(8'h00, 8, rx, oa, ob);
    cs_hi();
    chk("ien_rd", rx, DRDY ? 8'h80 : 8'h00);
    pulse_sample(16'h0102, 16'h0304, 16'h0506);
    repeat (2) @(negedge clk);
    chk("int_set", int1, DRDY);
    cs_lo();
    xfer(8'hF2, 8, rx, oa, ob);
    for (int k = 0; k < 6; k++) begin
      xfer(8'h00, 8, rx, oa, ob);
      chk($sformatf("int_rd_b%0d", k), rx, e3[k]);
      if (k == 4) chk("int_hold", int1, DRDY);
    end
    repeat (2) @(negedge clk);
    chk("int_clr", int1, 1'b0);
    cs_hi();
    chk("int_end", int1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
